// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-network partial-sum stage:
// default widths, map geometry and the accumulation state encoding.
package bnn_pkg;

    localparam int IL_DEF  = 6;    // signed popcount width, range -9..+9
    localparam int AW_DEF  = 10;   // signed accumulator width
    localparam int CH_DEF  = 16;   // input channels folded into one output map
    localparam int PIX_DEF = 144;  // 12x12 pixels per map

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        ACCUM = 2'd2,
        LAST  = 2'd3
    } psum_state_t;

endpackage

// File: rtl/bnn_psum_ram.sv
// Partial-sum buffer: PIX words of AW bits, combinational read and
// synchronous write on a single shared address. Contents are not reset
// because the first channel pass overwrites every word.
module bnn_psum_ram #(
    parameter int AW  = 10,
    parameter int PIX = 144,
    parameter int PW  = 8
) (
    input  logic                 iCLK,
    input  logic                 iWE,
    input  logic [PW-1:0]        iADDR,
    input  logic signed [AW-1:0] iWDATA,
    output logic signed [AW-1:0] oRDATA
);

    logic signed [AW-1:0] mem [PIX];

    // Read is asynchronous so read-modify-write completes in one cycle.
    assign oRDATA = mem[iADDR];

    // Single write port, no reset on the storage array.
    always_ff @(posedge iCLK) begin
        if (iWE) begin
            mem[iADDR] <= iWDATA;
        end
    end

endmodule

// File: rtl/bnn_psum_binarize.sv
// Accumulates signed XNOR-popcount samples across CH channel passes per
// pixel and, on the final pass, compares each sum with a per-frame
// threshold to produce a 1-bit activation stream.
// Optional build macro: BNN_PSUM_SAT_EN (adds saturate instead of wrapping).
module bnn_psum_binarize
    import bnn_pkg::*;
#(
    parameter int IL  = IL_DEF,
    parameter int AW  = AW_DEF,
    parameter int CH  = CH_DEF,
    parameter int PIX = PIX_DEF
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iSTART,
    input  logic [AW-1:0] iTHRESH,
    input  logic          iVALID,
    input  logic [IL-1:0] iDATA,
    output logic          oVALID,
    output logic          oDATA,
    output logic          oDONE,
    output logic          oBUSY
);

    localparam int PW = (PIX > 1) ? $clog2(PIX) : 1;
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    psum_state_t          state, stateNxt;
    logic [PW-1:0]        pix, pixNxt;
    logic [CW-1:0]        ch, chNxt;
    logic signed [AW-1:0] thresh, threshNxt;
    logic                 vldNxt, dataNxt, doneNxt;
    logic                 wrEn;
    logic signed [AW-1:0] wrData;
    logic signed [AW-1:0] rdData;
    logic signed [AW-1:0] ext;
    logic signed [AW-1:0] sumAcc;
    logic signed [AW-1:0] sumLast;
    logic                 lastPix;

    // Accumulator add: clamps to the AW range when saturation is built in,
    // otherwise wraps modulo 2^AW.
    function automatic logic signed [AW-1:0] psumAdd(
        input logic signed [AW-1:0] a,
        input logic signed [AW-1:0] b
    );
`ifdef BNN_PSUM_SAT_EN
        logic signed [AW:0] full;
        full = (AW+1)'(a) + (AW+1)'(b);
        if (full[AW] != full[AW-1]) begin
            psumAdd = full[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            psumAdd = full[AW-1:0];
        end
`else
        psumAdd = a + b;
`endif
    endfunction

    bnn_psum_ram #(
        .AW  (AW),
        .PIX (PIX),
        .PW  (PW)
    ) uRam (
        .iCLK   (iCLK),
        .iWE    (wrEn),
        .iADDR  (pix),
        .iWDATA (wrData),
        .oRDATA (rdData)
    );

    assign ext     = AW'($signed(iDATA));
    assign sumAcc  = psumAdd(rdData, ext);
    assign sumLast = (CH == 1) ? ext : sumAcc;
    assign lastPix = (pix == PW'(PIX - 1));

    // Busy from the first cycle after the start pulse through the done pulse.
    assign oBUSY = (state != IDLE) | oDONE;

    // Next-state, counter, buffer-write and output decode for one sample.
    always_comb begin
        stateNxt  = state;
        pixNxt    = pix;
        chNxt     = ch;
        threshNxt = thresh;
        wrEn      = 1'b0;
        wrData    = sumAcc;
        vldNxt    = 1'b0;
        dataNxt   = 1'b0;
        doneNxt   = 1'b0;
        if (iSTART) begin
            // Start aborts any frame and drops the sample in this cycle.
            stateNxt  = (CH == 1) ? LAST : FIRST;
            pixNxt    = '0;
            chNxt     = '0;
            threshNxt = iTHRESH;
        end else if (iVALID && (state != IDLE)) begin
            pixNxt = lastPix ? '0 : pix + 1'b1;
            if (lastPix) begin
                chNxt = ch + 1'b1;
            end
            case (state)
                FIRST: begin
                    wrEn   = 1'b1;
                    wrData = ext;
                    if (lastPix) begin
                        stateNxt = (CH > 2) ? ACCUM : LAST;
                    end
                end
                ACCUM: begin
                    wrEn   = 1'b1;
                    wrData = sumAcc;
                    if (lastPix && (ch == CW'(CH - 2))) begin
                        stateNxt = LAST;
                    end
                end
                LAST: begin
                    vldNxt  = 1'b1;
                    dataNxt = (sumLast >= thresh);
                    if (lastPix) begin
                        stateNxt = IDLE;
                        doneNxt  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, counters, threshold and registered output strobes.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state  <= IDLE;
            pix    <= '0;
            ch     <= '0;
            thresh <= '0;
            oVALID <= 1'b0;
            oDATA  <= 1'b0;
            oDONE  <= 1'b0;
        end else begin
            state  <= stateNxt;
            pix    <= pixNxt;
            ch     <= chNxt;
            thresh <= threshNxt;
            oVALID <= vldNxt;
            oDATA  <= dataNxt;
            oDONE  <= doneNxt;
        end
    end

endmodule

// File: tb/tb_bnn_psum_binarize.sv
// Randomized bench for bnn_psum_binarize: three instances (default,
// narrow accumulator, small two-channel map) share the sample bus and
// are exercised one at a time against a per-pixel arithmetic model.
module tb_bnn_psum_binarize;

    logic       clk = 1'b0;
    logic       rst;
    logic       iVALID;
    logic [5:0] iDATA;
    logic       startA, startB, startC;
    logic [9:0] threshA, threshC;
    logic [5:0] threshB;
    logic       vA, dA, doneA, busyA;
    logic       vB, dB, doneB, busyB;
    logic       vC, dC, doneC, busyC;

    int  samp [16][144];
    int  sel;
    bit  outQ [$];
    bit  refQ [$];
    int  doneCnt, doneAt;
    bit  prevDone, busyNow;
    int  nChecks, nErr;

    always #5 clk = ~clk;

    bnn_psum_binarize uDutA (
        .iCLK(clk), .iRST(rst), .iSTART(startA), .iTHRESH(threshA),
        .iVALID(iVALID), .iDATA(iDATA),
        .oVALID(vA), .oDATA(dA), .oDONE(doneA), .oBUSY(busyA)
    );

    bnn_psum_binarize #(.IL(6), .AW(6), .CH(16), .PIX(4)) uDutB (
        .iCLK(clk), .iRST(rst), .iSTART(startB), .iTHRESH(threshB),
        .iVALID(iVALID), .iDATA(iDATA),
        .oVALID(vB), .oDATA(dB), .oDONE(doneB), .oBUSY(busyB)
    );

    bnn_psum_binarize #(.CH(2), .PIX(4)) uDutC (
        .iCLK(clk), .iRST(rst), .iSTART(startC), .iTHRESH(threshC),
        .iVALID(iVALID), .iDATA(iDATA),
        .oVALID(vC), .oDATA(dC), .oDONE(doneC), .oBUSY(busyC)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        nChecks++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: running per-pixel sum over channels, each add wrapped or
    // clamped to the accumulator range, then compared with the threshold.
    function automatic bit expBit(input int nCh, input int p, input int aw, input int th);
        longint s  = 0;
        longint m  = longint'(1) <<< aw;
        longint lo = -(m / 2);
        longint hi = m / 2 - 1;
        for (int c = 0; c < nCh; c++) begin
            s = s + samp[c][p];
`ifdef BNN_PSUM_SAT_EN
            if (s > hi) s = hi;
            if (s < lo) s = lo;
`else
            s = s & (m - 1);
            if (s > hi) s = s - m;
`endif
        end
        return (s >= th);
    endfunction

    task automatic tick();
        logic v, d, dn, b;
        @(negedge clk);
        case (sel)
            0:       {v, d, dn, b} = {vA, dA, doneA, busyA};
            1:       {v, d, dn, b} = {vB, dB, doneB, busyB};
            default: {v, d, dn, b} = {vC, dC, doneC, busyC};
        endcase
        if (prevDone) check("busyDrop", b, 0);
        if (v) outQ.push_back(d);
        if (dn) begin
            doneCnt++;
            doneAt = outQ.size();
            check("doneBusy", b, 1);
            check("doneWithValid", v, 1);
        end
        prevDone = dn;
        busyNow  = b;
    endtask

    task automatic fillRandom(input int nCh, input int nPix);
        for (int c = 0; c < nCh; c++)
            for (int p = 0; p < nPix; p++)
                samp[c][p] = int'($urandom_range(0, 18)) - 9;
    endtask

    task automatic fillConst(input int nCh, input int nPix, input int v);
        for (int c = 0; c < nCh; c++)
            for (int p = 0; p < nPix; p++)
                samp[c][p] = v;
    endtask

    // Start pulse carries a valid +9 sample that must be dropped.
    task automatic startPulse(input int s, input int th);
        sel      = s;
        prevDone = 1'b0;
        iVALID   = 1'b1;
        iDATA    = 6'd9;
        case (s)
            0:       begin startA = 1'b1; threshA = 10'(th); end
            1:       begin startB = 1'b1; threshB = 6'(th);  end
            default: begin startC = 1'b1; threshC = 10'(th); end
        endcase
        outQ.delete();
        doneCnt = 0;
        doneAt  = -1;
        tick();
        startA = 1'b0; startB = 1'b0; startC = 1'b0;
        iVALID = 1'b0;
        check("busyAfterStart", busyNow, 1);
    endtask

    task automatic sendSamples(input int nCh, input int nPix, input int gap,
                               input int stopC, input int stopP);
        for (int c = 0; c < nCh; c++) begin
            for (int p = 0; p < nPix; p++) begin
                if (c == stopC && p == stopP) begin
                    iVALID = 1'b0;
                    return;
                end
                while (int'($urandom_range(0, 99)) < gap) begin
                    iVALID = 1'b0;
                    iDATA  = 6'($urandom);
                    tick();
                end
                iVALID = 1'b1;
                iDATA  = 6'(samp[c][p]);
                tick();
            end
        end
        iVALID = 1'b0;
    endtask

    task automatic finishFrame(input int nCh, input int nPix, input int aw, input int th);
        int n = 0;
        iVALID = 1'b0;
        while (doneCnt == 0 && n < 20) begin
            tick();
            n++;
        end
        check("doneSeen", (doneCnt > 0), 1);
        tick();
        check("validCount", outQ.size(), nPix);
        check("doneCount", doneCnt, 1);
        check("doneAt", doneAt, nPix);
        for (int p = 0; p < nPix && p < outQ.size(); p++)
            check($sformatf("pix%0d", p), outQ[p], expBit(nCh, p, aw, th));
    endtask

    task automatic runFrame(input int s, input int nCh, input int nPix, input int aw,
                            input int th, input int gap);
        startPulse(s, th);
        sendSamples(nCh, nPix, gap, -1, -1);
        finishFrame(nCh, nPix, aw, th);
    endtask

    initial begin
        int lit[4];
        int th;
        nChecks = 0; nErr = 0;
        sel = 0; prevDone = 0; doneCnt = 0; doneAt = -1;
        rst = 1'b1; iVALID = 1'b0; iDATA = '0;
        startA = 0; startB = 0; startC = 0;
        threshA = '0; threshB = '0; threshC = '0;
        repeat (3) @(negedge clk);
        check("rstValidA", vA, 0); check("rstDataA", dA, 0);
        check("rstDoneA", doneA, 0); check("rstBusyA", busyA, 0);
        check("rstBusyB", busyB, 0); check("rstBusyC", busyC, 0);
        rst = 1'b0;
        tick();

        // Two-channel directed map: sums {0,-1,0,-1} against threshold 0.
        samp[0][0] = 3;  samp[0][1] = -5; samp[0][2] = 9;  samp[0][3] = 0;
        samp[1][0] = -3; samp[1][1] = 4;  samp[1][2] = -9; samp[1][3] = -1;
        lit = '{1, 0, 1, 0};
        runFrame(2, 2, 4, 10, 0, 0);
        for (int p = 0; p < 4 && p < outQ.size(); p++)
            check($sformatf("directed%0d", p), outQ[p], lit[p]);

        // Full-scale sum of 144 right at and just above the threshold.
        fillConst(16, 144, 9);
        runFrame(0, 16, 144, 10, 144, 0);
        for (int p = 0; p < 144 && p < outQ.size(); p++) check("all9Eq", outQ[p], 1);
        runFrame(0, 16, 144, 10, 145, 0);
        for (int p = 0; p < 144 && p < outQ.size(); p++) check("all9Above", outQ[p], 0);

        // Random map, gap-free then with 30% idle cycles; streams must agree.
        fillRandom(16, 144);
        th = int'($urandom_range(0, 16)) - 8;
        runFrame(0, 16, 144, 10, th, 0);
        refQ = outQ;
        runFrame(0, 16, 144, 10, th, 30);
        check("gapLen", outQ.size(), refQ.size());
        for (int p = 0; p < refQ.size() && p < outQ.size(); p++)
            check($sformatf("gapMatch%0d", p), outQ[p], refQ[p]);

        // Restart at channel 5 pixel 70: no output, no done for the old frame.
        fillRandom(16, 144);
        startPulse(0, 100);
        sendSamples(16, 144, 0, 5, 70);
        tick();
        check("abortNoValid", outQ.size(), 0);
        check("abortNoDone", doneCnt, 0);
        fillRandom(16, 144);
        th = int'($urandom_range(0, 10)) - 5;
        runFrame(0, 16, 144, 10, th, 10);

        // Asynchronous reset while accumulating, then a clean frame.
        fillRandom(16, 144);
        startPulse(0, 3);
        sendSamples(16, 144, 0, 3, 10);
        check("busyBeforeRst", busyNow, 1);
        #2 rst = 1'b1;
        #1;
        check("midRstValid", vA, 0); check("midRstData", dA, 0);
        check("midRstDone", doneA, 0); check("midRstBusy", busyA, 0);
        tick(); tick();
        rst = 1'b0;
        prevDone = 1'b0;
        fillRandom(16, 144);
        th = int'($urandom_range(0, 10)) - 5;
        runFrame(0, 16, 144, 10, th, 20);

        // Narrow accumulator: 16 x +9 overflows a 6-bit sum.
        fillConst(16, 4, 9);
        runFrame(1, 16, 4, 6, 31, 0);
        for (int p = 0; p < 4 && p < outQ.size(); p++)
`ifdef BNN_PSUM_SAT_EN
            check("narrowSat", outQ[p], 1);
`else
            check("narrowWrap", outQ[p], 0);
`endif
        fillRandom(16, 4);
        th = int'($urandom_range(0, 40)) - 20;
        runFrame(1, 16, 4, 6, th, 25);

        // Small map with random data and negative threshold.
        fillRandom(2, 4);
        th = -int'($urandom_range(0, 6));
        runFrame(2, 2, 4, 10, th, 30);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
